// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   A chain of STAGES pipeline registers placed between two datapath stages.
//   Each stage carries a valid bit, a control field and a data field. The
//   control field is forced to zero whenever its entry is not valid, so
//   downstream write enables cannot fire on a bubble. The data field is only
//   cleared by reset.
//
// Ports
//   CLK        rising-edge clock
//   RESET      asynchronous, active-high reset (clears all stages and counter)
//   STALL      global hold for every stage
//   FLUSH      per-stage squash; bit i turns stage i into a bubble
//   CNT_CLR    synchronous clear of STALL_CNT
//   VALID_IN   input entry is a real instruction
//   CTRL_IN    input control field
//   DATA_IN    input data field
//   VALID_OUT  valid bit of the last stage
//   CTRL_OUT   control field of the last stage
//   DATA_OUT   data field of the last stage
//   OCCUPANCY  number of stages currently holding valid entries
//   STALL_CNT  saturating count of cycles a valid output was held by STALL

module pipe_stage_chain #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic [STAGES-1:0] FLUSH,
  input  logic              CNT_CLR,
  input  logic              VALID_IN,
  input  logic [CTRL_W-1:0] CTRL_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              VALID_OUT,
  output logic [CTRL_W-1:0] CTRL_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [OCC_W-1:0]  OCCUPANCY,
  output logic [CNT_W-1:0]  STALL_CNT
);

  logic              v_q   [STAGES];
  logic              v_d   [STAGES];
  logic [CTRL_W-1:0] c_q   [STAGES];
  logic [CTRL_W-1:0] c_d   [STAGES];
  logic [DATA_W-1:0] d_q   [STAGES];
  logic [DATA_W-1:0] d_d   [STAGES];

  // Value each stage would take on a normal advancing edge.
  logic              ld_v  [STAGES];
  logic [CTRL_W-1:0] ld_c  [STAGES];
  logic [DATA_W-1:0] ld_d  [STAGES];

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [OCC_W-1:0]  occ;

  assign ld_v[0] = VALID_IN;
  assign ld_c[0] = VALID_IN ? CTRL_IN : '0;
  assign ld_d[0] = DATA_IN;

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_feed
    // An upstream bubble already has a zero control field.
    assign ld_v[gi] = v_q[gi-1];
    assign ld_c[gi] = c_q[gi-1];
    assign ld_d[gi] = d_q[gi-1];
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      v_d[i] = v_q[i];
      c_d[i] = c_q[i];
      d_d[i] = d_q[i];
      if (FLUSH[i]) begin
        // Flush beats stall for valid/control; data still follows the stall.
        v_d[i] = 1'b0;
        c_d[i] = '0;
        if (!STALL) d_d[i] = ld_d[i];
      end else if (!STALL) begin
        v_d[i] = ld_v[i];
        c_d[i] = ld_c[i];
        d_d[i] = ld_d[i];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (STALL && v_q[STAGES-1] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ = occ + OCC_W'(v_q[i]);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= v_d[i];
        c_q[i] <= c_d[i];
        d_q[i] <= d_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  assign VALID_OUT = v_q[STAGES-1];
  assign CTRL_OUT  = c_q[STAGES-1];
  assign DATA_OUT  = d_q[STAGES-1];
  assign OCCUPANCY = occ;
  assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain with three stages and a 4-bit stall counter.
// Valid entries expected to leave the chain are queued when issued; a
// separate monitor pops and compares each entry as it leaves the last stage.

module tb_pipe_stage_chain;
  localparam int S  = 3;
  localparam int CW = 8;
  localparam int DW = 101;
  localparam int NW = 4;
  localparam int OW = $clog2(S + 1);

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          STALL = 1'b0;
  logic [S-1:0]  FLUSH = '0;
  logic          CNT_CLR = 1'b0;
  logic          VALID_IN = 1'b0;
  logic [CW-1:0] CTRL_IN = '0;
  logic [DW-1:0] DATA_IN = '0;
  logic          VALID_OUT;
  logic [CW-1:0] CTRL_OUT;
  logic [DW-1:0] DATA_OUT;
  logic [OW-1:0] OCCUPANCY;
  logic [NW-1:0] STALL_CNT;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .STAGES(S), .CNT_W(NW)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .CNT_CLR(CNT_CLR),
    .VALID_IN(VALID_IN), .CTRL_IN(CTRL_IN), .DATA_IN(DATA_IN),
    .VALID_OUT(VALID_OUT), .CTRL_OUT(CTRL_OUT), .DATA_OUT(DATA_OUT),
    .OCCUPANCY(OCCUPANCY), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    VALID_IN = 1'b0;
    CTRL_IN  = '0;
    DATA_IN  = '0;
  endtask

  task automatic issue(input logic [7:0] c, input logic [7:0] d, input bit expect_out);
    VALID_IN = 1'b1;
    CTRL_IN  = c;
    DATA_IN  = DW'(d);
    if (expect_out) sb.push_back('{c: c, d: DW'(d)});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 128'(VALID_OUT), 128'h0);
    chk({nm, "_ctrl"},  128'(CTRL_OUT),  128'h0);
    chk({nm, "_data"},  128'(DATA_OUT),  128'h0);
    chk({nm, "_occ"},   128'(OCCUPANCY), 128'h0);
    chk({nm, "_cnt"},   128'(STALL_CNT), 128'h0);
  endtask

  // Monitor: an entry leaves the chain at the coming edge when it is valid,
  // not stalled and not flushed at the last stage.
  initial begin
    ent_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (!RESET && VALID_OUT && !STALL && !FLUSH[S-1]) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got data %0h expected no entry", DATA_OUT);
        end else begin
          e = sb.pop_front();
          chk("sb_ctrl", 128'(CTRL_OUT), 128'(e.c));
          chk("sb_data", 128'(DATA_OUT), 128'(e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted between edges with every input nonzero.
    STALL = 1'b1; FLUSH = '1; CNT_CLR = 1'b1;
    VALID_IN = 1'b1; CTRL_IN = 8'hFF; DATA_IN = '1;
    #2 RESET = 1'b1;
    #1 chk_all_zero("rst_async");
    @(negedge CLK);
    chk_all_zero("rst_held");
    @(negedge CLK);
    RESET = 1'b0; STALL = 1'b0; FLUSH = '0; CNT_CLR = 1'b0; idle();
    cyc();
    chk_all_zero("rst_after");

    // Streaming A,B,C.
    issue(8'hA5, 8'h11, 1'b1); cyc();
    issue(8'hA5, 8'h22, 1'b1); cyc();
    issue(8'hA5, 8'h33, 1'b1); cyc();
    chk("stream_valid", 128'(VALID_OUT), 128'h1);
    chk("stream_ctrl",  128'(CTRL_OUT),  128'hA5);
    chk("stream_data",  128'(DATA_OUT),  128'h11);
    chk("stream_occ",   128'(OCCUPANCY), 128'h3);

    // Stall hold for 4 cycles with A at the output.
    idle(); STALL = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("stall_data", 128'(DATA_OUT),  128'h11);
      chk("stall_occ",  128'(OCCUPANCY), 128'h3);
    end
    chk("stall_cnt4", 128'(STALL_CNT), 128'h4);
    STALL = 1'b0;
    cyc(); cyc(); cyc();
    chk("drain_occ", 128'(OCCUPANCY), 128'h0);

    // Flush of the last stage during a stall: D squashed, E survives.
    issue(8'h3C, 8'h44, 1'b0); cyc();
    issue(8'h0F, 8'h55, 1'b1); cyc();
    idle(); cyc();
    STALL = 1'b1; FLUSH = 3'b100;
    cyc();
    chk("flush_valid", 128'(VALID_OUT), 128'h0);
    chk("flush_ctrl",  128'(CTRL_OUT),  128'h0);
    chk("flush_data",  128'(DATA_OUT),  128'h44);
    chk("flush_occ",   128'(OCCUPANCY), 128'h1);
    chk("flush_cnt",   128'(STALL_CNT), 128'h5);
    FLUSH = '0;
    cyc();
    chk("bubble_valid", 128'(VALID_OUT), 128'h0);
    chk("bubble_data",  128'(DATA_OUT),  128'h44);
    chk("bubble_cnt",   128'(STALL_CNT), 128'h5);
    STALL = 1'b0;
    cyc();
    chk("release_valid", 128'(VALID_OUT), 128'h1);
    chk("release_data",  128'(DATA_OUT),  128'h55);
    cyc(); cyc();

    // Invalid input: control zeroed, data carried.
    VALID_IN = 1'b0; CTRL_IN = 8'hFF; DATA_IN = DW'(8'h5A);
    cyc();
    chk("inv_occ", 128'(OCCUPANCY), 128'h0);
    idle(); cyc(); cyc();
    chk("inv_valid", 128'(VALID_OUT), 128'h0);
    chk("inv_ctrl",  128'(CTRL_OUT),  128'h0);
    chk("inv_data",  128'(DATA_OUT),  128'h5A);

    // Counter saturation and clear-over-increment.
    CNT_CLR = 1'b1; cyc();
    chk("clr_cnt", 128'(STALL_CNT), 128'h0);
    CNT_CLR = 1'b0;
    issue(8'h81, 8'h66, 1'b1); cyc();
    idle(); cyc(); cyc();
    STALL = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 14) chk("sat_cnt14", 128'(STALL_CNT), 128'hE);
    end
    chk("sat_cnt",   128'(STALL_CNT), 128'hF);
    chk("sat_valid", 128'(VALID_OUT), 128'h1);
    chk("sat_data",  128'(DATA_OUT),  128'h66);
    CNT_CLR = 1'b1;
    cyc();
    chk("clr_prio_cnt", 128'(STALL_CNT), 128'h0);
    CNT_CLR = 1'b0; STALL = 1'b0;
    cyc(); cyc(); cyc();

    // Reset mid-operation discards everything in flight.
    issue(8'hC3, 8'h77, 1'b0); cyc();
    issue(8'hC3, 8'h78, 1'b0); cyc();
    issue(8'hC3, 8'h79, 1'b0); cyc();
    idle(); STALL = 1'b1;
    cyc(); cyc();
    chk("pre_rst_cnt", 128'(STALL_CNT), 128'h2);
    #2 RESET = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge CLK);
    RESET = 1'b0; STALL = 1'b0;
    cyc();
    chk_all_zero("mid_rst_after");
    cyc(); cyc();

    chk("sb_empty", 128'(sb.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
